// File: rtl/trigger_matrix_hs.sv
// rtl/trigger_matrix_hs.sv - registered trigger router with per-path 4-phase handshakes for one DMA channel
// Optional TRIG_SYNC_EN: 2-flop synchronisers on trigin_req and trigout_ack.
module trigger_matrix_hs #(
  parameter int NUM_TRIGIN  = 4,
  parameter int NUM_TRIGOUT = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_TRIGIN-1:0]  trigin_req,
  output logic [NUM_TRIGIN-1:0]  trigin_ack,
  output logic [NUM_TRIGOUT-1:0] trigout_req,
  input  logic [NUM_TRIGOUT-1:0] trigout_ack,
  input  logic                   ch_enable,
  input  logic                   use_src_trigin,
  input  logic                   use_des_trigin,
  input  logic                   use_trigout,
  input  logic [1:0]             src_trigin_type,
  input  logic [1:0]             des_trigin_type,
  input  logic [1:0]             trigout_type,
  input  logic [7:0]             src_trigin_sel,
  input  logic [7:0]             des_trigin_sel,
  input  logic [5:0]             trigout_sel,
  output logic                   src_trig_req,
  output logic                   des_trig_req,
  input  logic                   ch_src_ack,
  input  logic                   ch_des_ack,
  input  logic                   ch_trigout_req,
  output logic                   ch_trigout_ack,
  input  logic                   err_clr,
  output logic                   srctriginsel_err,
  output logic                   destriginsel_err,
  output logic                   trigoutsel_err
);

  localparam logic [1:0] TYPE_HW = 2'b10;

  typedef enum logic [1:0] {
    TIN_IDLE = 2'd0,
    TIN_REQ  = 2'd1,
    TIN_ACK  = 2'd2
  } tin_state_e;

  typedef enum logic [1:0] {
    TOUT_IDLE = 2'd0,
    TOUT_REQ  = 2'd1,
    TOUT_WAIT = 2'd2
  } tout_state_e;

  logic [NUM_TRIGIN-1:0]  trigin_req_s;
  logic [NUM_TRIGOUT-1:0] trigout_ack_s;

`ifdef TRIG_SYNC_EN
  logic [NUM_TRIGIN-1:0]  trigin_req_m;
  logic [NUM_TRIGOUT-1:0] trigout_ack_m;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trigin_req_m  <= '0;
      trigin_req_s  <= '0;
      trigout_ack_m <= '0;
      trigout_ack_s <= '0;
    end else begin
      trigin_req_m  <= trigin_req;
      trigin_req_s  <= trigin_req_m;
      trigout_ack_m <= trigout_ack;
      trigout_ack_s <= trigout_ack_m;
    end
  end
`else
  assign trigin_req_s  = trigin_req;
  assign trigout_ack_s = trigout_ack;
`endif

  // Select validity; a src/des collision blocks both paths.
  logic src_hw, des_hw, tout_hw, same_sel;
  logic src_err, des_err, tout_err;

  assign src_hw   = use_src_trigin && (src_trigin_type == TYPE_HW);
  assign des_hw   = use_des_trigin && (des_trigin_type == TYPE_HW);
  assign tout_hw  = use_trigout && (trigout_type == TYPE_HW);
  assign same_sel = src_hw && des_hw && (src_trigin_sel == des_trigin_sel);
  assign src_err  = src_hw && (({1'b0, src_trigin_sel} >= 9'(NUM_TRIGIN)) || same_sel);
  assign des_err  = des_hw && (({1'b0, des_trigin_sel} >= 9'(NUM_TRIGIN)) || same_sel);
  assign tout_err = tout_hw && ({1'b0, trigout_sel} >= 7'(NUM_TRIGOUT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      srctriginsel_err <= 1'b0;
      destriginsel_err <= 1'b0;
      trigoutsel_err   <= 1'b0;
    end else begin
      srctriginsel_err <= src_err  || (srctriginsel_err && !err_clr);
      destriginsel_err <= des_err  || (destriginsel_err && !err_clr);
      trigoutsel_err   <= tout_err || (trigoutsel_err   && !err_clr);
    end
  end

  logic [1:0] path_hw, path_err, path_ch_ack;

  assign path_hw     = {des_hw, src_hw};
  assign path_err    = {des_err, src_err};
  assign path_ch_ack = {ch_des_ack, ch_src_ack};

  // Path 0 is source, path 1 is destination; both run the same handshake.
  for (genvar p = 0; p < 2; p++) begin : g_path
    tin_state_e            state_q, state_d;
    logic [7:0]            sel_in, sel_q, sel_d;
    logic                  req_at_in, req_at_q;
    logic                  trig_req;
    logic [NUM_TRIGIN-1:0] ack_vec;

    assign sel_in = (p == 0) ? src_trigin_sel : des_trigin_sel;

    always_comb begin
      req_at_in = 1'b0;
      req_at_q  = 1'b0;
      for (int i = 0; i < NUM_TRIGIN; i++) begin
        if (sel_in == 8'(i)) req_at_in = trigin_req_s[i];
        if (sel_q == 8'(i))  req_at_q  = trigin_req_s[i];
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_q <= TIN_IDLE;
        sel_q   <= '0;
      end else begin
        state_q <= state_d;
        sel_q   <= sel_d;
      end
    end

    always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      if (path_err[p]) begin
        state_d = TIN_IDLE;
      end else begin
        unique case (state_q)
          TIN_IDLE: begin
            if (path_hw[p] && ch_enable && req_at_in) begin
              state_d = TIN_REQ;
              sel_d   = sel_in;
            end
          end
          TIN_REQ: begin
            if (path_ch_ack[p]) state_d = TIN_ACK;
          end
          TIN_ACK: begin
            // Only a released request returns to IDLE, so a held level never re-fires.
            if (!req_at_q) state_d = TIN_IDLE;
          end
          default: state_d = TIN_IDLE;
        endcase
      end
    end

    assign trig_req = (state_q == TIN_REQ);

    always_comb begin
      ack_vec = '0;
      for (int i = 0; i < NUM_TRIGIN; i++) begin
        ack_vec[i] = (state_q == TIN_ACK) && (sel_q == 8'(i));
      end
    end
  end

  assign src_trig_req = g_path[0].trig_req;
  assign des_trig_req = g_path[1].trig_req;
  assign trigin_ack   = g_path[0].ack_vec | g_path[1].ack_vec;

  tout_state_e tout_state_q, tout_state_d;
  logic [5:0]  tout_sel_q, tout_sel_d;
  logic        tout_ack_at_q;
  logic        tout_pulse_d;

  always_comb begin
    tout_ack_at_q = 1'b0;
    for (int i = 0; i < NUM_TRIGOUT; i++) begin
      if (tout_sel_q == 6'(i)) tout_ack_at_q = trigout_ack_s[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tout_state_q   <= TOUT_IDLE;
      tout_sel_q     <= '0;
      ch_trigout_ack <= 1'b0;
    end else begin
      tout_state_q   <= tout_state_d;
      tout_sel_q     <= tout_sel_d;
      ch_trigout_ack <= tout_pulse_d;
    end
  end

  always_comb begin
    tout_state_d = tout_state_q;
    tout_sel_d   = tout_sel_q;
    tout_pulse_d = 1'b0;
    if (tout_err) begin
      tout_state_d = TOUT_IDLE;
    end else begin
      unique case (tout_state_q)
        TOUT_IDLE: begin
          if (tout_hw && ch_trigout_req) begin
            tout_state_d = TOUT_REQ;
            tout_sel_d   = trigout_sel;
          end
        end
        TOUT_REQ: begin
          if (tout_ack_at_q) begin
            tout_state_d = TOUT_WAIT;
            tout_pulse_d = 1'b1;
          end
        end
        TOUT_WAIT: begin
          // Both sides must release before re-arming, otherwise a held request double-fires.
          if (!tout_ack_at_q && !ch_trigout_req) tout_state_d = TOUT_IDLE;
        end
        default: tout_state_d = TOUT_IDLE;
      endcase
    end
  end

  always_comb begin
    trigout_req = '0;
    for (int i = 0; i < NUM_TRIGOUT; i++) begin
      trigout_req[i] = (tout_state_q == TOUT_REQ) && (tout_sel_q == 6'(i));
    end
  end

endmodule
